pipeline_skid_reg: RTL
======================

Name: pipeline_skid_reg

Overview:
Parametrised elastic pipeline register: a two-entry skid buffer with a valid/ready handshake on both sides, a synchronous flush and a programmable reset value. It replaces plain resettable flip-flops between processor pipeline stages. Downstream stalls are absorbed without a combinational ready path from output to input. Flush supports branch/exception squash.

Parameters:
WIDTH, 32, payload width in bits (>=1)
RESET_VALUE, 0 (WIDTH bits), value loaded into both data registers on reset and flush

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
flush  input  1  synchronous squash of all held entries
in_valid  input  1  upstream offers in_data
in_ready  output  1  block can accept; depends on registered state only
in_data  input  WIDTH  upstream payload
out_valid  output  1  out_data holds a valid entry
out_ready  input  1  downstream accepts out_data this cycle
out_data  output  WIDTH  head entry payload, driven from main register
occupancy  output  2  entries held: 0, 1 or 2

Behaviour:
- Reset (async, active-high; clock clk):
  - state EMPTY
  - main and skid registers = RESET_VALUE
  - out_valid=0, occupancy=0, in_ready=1
- Storage: main register (head, drives out_data) and skid register (second entry).
- Handshakes:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - in_ready = (state != FULL). No combinational path from out_ready to in_ready.
- States and transitions (absent flush):
  - EMPTY: input transfer -> ONE, main<=in_data. Otherwise stay.
  - ONE:
    - input & output transfer -> ONE, main<=in_data
    - input only -> FULL, skid<=in_data
    - output only -> EMPTY
    - neither -> hold
  - FULL (in_ready=0):
    - output transfer -> ONE, main<=skid, skid<=RESET_VALUE
    - otherwise hold
- Outputs:
  - out_valid = (state != EMPTY)
  - occupancy: EMPTY=0, ONE=1, FULL=2
- Latency: 1 cycle from input transfer to out_valid when EMPTY. Throughput is 1 entry/cycle with out_ready held high.
- Ordering: strict FIFO; no entry is lost or duplicated.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid must not change (except on flush or reset).
- Flush has highest synchronous priority:
  - next state EMPTY; main and skid <= RESET_VALUE
  - an input transfer in the same cycle is discarded (in_ready is still 1 if not FULL)
  - an output transfer in the same cycle is still considered taken by downstream
- Reset asserted mid-operation: immediate return to reset values, independent of clk. Deassertion is synchronised externally.
- X-safety: in_data is not captured unless an input transfer occurs. Data registers hold otherwise.

Optional Feature:
- Macro: PIPELINE_SKID_REG_PERF_EN.
- Defined:
  - Adds output stall_cycles (32 bits): counts cycles with out_valid=1 & out_ready=0.
  - Adds output flush_drops (2 bits... widened to 16 bits): accumulates the number of valid entries discarded by flush.
  - Both counters saturate at all-ones and clear only on reset.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle: reset=1 for 2 cycles with in_valid=0 -> out_valid=0, occupancy=0, in_ready=1, out_data=RESET_VALUE.
- Streaming: out_ready=1, in_valid=1 with data 0x10..0x17 on consecutive cycles -> out_data 0x10..0x17 one cycle later, in order, occupancy stays 1, no bubbles.
- Skid fill/drain:
  - Send 0xA1 then 0xA2 with out_ready=0 -> occupancy=2, in_ready=0, out_data=0xA1 stable.
  - Raise out_ready -> 0xA1 then 0xA2 delivered, back to EMPTY.
- Flush when FULL, with in_valid=1 and in_data=0xFF the same cycle -> next cycle occupancy=0, out_valid=0, out_data=RESET_VALUE, 0xFF never appears.
- Async reset mid-stream: assert reset between clock edges while FULL -> out_valid drops immediately, state EMPTY; after release, 0x33 accepted and delivered normally.
- PERF_EN:
  - Hold out_ready=0 for 5 cycles with one entry -> stall_cycles=5.
  - Flush while FULL -> flush_drops increments by 2.

Source files
------------

// File: rtl/pipeline_skid_reg.sv
// pipeline_skid_reg: two-entry elastic pipeline register (skid buffer).
// The main register is the head entry and drives out_data. The skid register
// holds a second entry so that in_ready can come from registered state only.
// Synchronous flush squashes every held entry. The asynchronous active-high
// reset clears all state.
// Optional build macro PIPELINE_SKID_REG_PERF_EN adds two saturating
// counters: stall_cycles and flush_drops.
module pipeline_skid_reg #(
  parameter int unsigned      WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
`ifdef PIPELINE_SKID_REG_PERF_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [15:0]      flush_drops
`endif
);

  // The state encoding equals the number of held entries.
  localparam logic [1:0] StEmpty = 2'd0;
  localparam logic [1:0] StOne   = 2'd1;
  localparam logic [1:0] StFull  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_xfer, out_xfer;

  assign in_ready  = (state_q != StFull);
  assign out_valid = (state_q != StEmpty);
  assign out_data  = main_q;
  assign occupancy = state_q;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // Next-state and data-register update. Flush overrides every transfer.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = StEmpty;
      main_d  = RESET_VALUE;
      skid_d  = RESET_VALUE;
    end else begin
      case (state_q)
        StEmpty: begin
          if (in_xfer) begin
            state_d = StOne;
            main_d  = in_data;
          end
        end
        StOne: begin
          if (in_xfer && out_xfer) begin
            main_d = in_data;
          end else if (in_xfer) begin
            state_d = StFull;
            skid_d  = in_data;
          end else if (out_xfer) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (out_xfer) begin
            state_d = StOne;
            main_d  = skid_q;
            skid_d  = RESET_VALUE;
          end
        end
        default: begin
          state_d = StEmpty;
        end
      endcase
    end
  end

  // State and data registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StEmpty;
      main_q  <= RESET_VALUE;
      skid_q  <= RESET_VALUE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef PIPELINE_SKID_REG_PERF_EN
  logic [31:0] stall_q;
  logic [15:0] drops_q;
  logic [15:0] drop_inc;
  logic [16:0] drop_sum;

  // Entries lost to a flush; a head taken by downstream in that cycle is not lost.
  always_comb begin
    drop_inc = '0;
    if (flush) begin
      drop_inc = {14'd0, occupancy - {1'b0, out_xfer}};
    end
    drop_sum = {1'b0, drops_q} + {1'b0, drop_inc};
  end

  // Saturating performance counters, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      drops_q <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_q != '1)) begin
        stall_q <= stall_q + 32'd1;
      end
      drops_q <= drop_sum[16] ? '1 : drop_sum[15:0];
    end
  end

  assign stall_cycles = stall_q;
  assign flush_drops  = drops_q;
`endif

endmodule
